// File: rtl/reg_file_if.sv
// ============================================================================
// Module : reg_file_if
// Brief  : RoB commit, dispatcher read and rename bundle for reg_file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface reg_file_if #(
  parameter int TAG_WIDTH = 5,
  parameter int IDX_WIDTH = 5
);
  logic                 rdy_in;
  logic                 rollback_in;
  logic                 commit_en_from_rob;
  logic [IDX_WIDTH-1:0] rd_from_rob;
  logic [TAG_WIDTH-1:0] Q_from_rob;
  logic [31:0]          V_from_rob;
  logic [IDX_WIDTH-1:0] rs1_from_dispatcher;
  logic [IDX_WIDTH-1:0] rs2_from_dispatcher;
  logic [TAG_WIDTH-1:0] Q1_to_dispatcher;
  logic [31:0]          V1_to_dispatcher;
  logic [TAG_WIDTH-1:0] Q2_to_dispatcher;
  logic [31:0]          V2_to_dispatcher;
  logic                 rename_en_from_dispatcher;
  logic [IDX_WIDTH-1:0] rename_rd_from_dispatcher;
  logic [TAG_WIDTH-1:0] rename_Q_from_dispatcher;

  modport master (
    output rdy_in, rollback_in,
    output commit_en_from_rob, rd_from_rob, Q_from_rob, V_from_rob,
    output rs1_from_dispatcher, rs2_from_dispatcher,
    output rename_en_from_dispatcher, rename_rd_from_dispatcher, rename_Q_from_dispatcher,
    input  Q1_to_dispatcher, V1_to_dispatcher, Q2_to_dispatcher, V2_to_dispatcher
  );

  modport slave (
    input  rdy_in, rollback_in,
    input  commit_en_from_rob, rd_from_rob, Q_from_rob, V_from_rob,
    input  rs1_from_dispatcher, rs2_from_dispatcher,
    input  rename_en_from_dispatcher, rename_rd_from_dispatcher, rename_Q_from_dispatcher,
    output Q1_to_dispatcher, V1_to_dispatcher, Q2_to_dispatcher, V2_to_dispatcher
  );
endinterface

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// Module : reg_file
// Brief  : Architectural register file with rename-tag table and commit bypass.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file #(
  parameter int REG_NUM   = 32,
  parameter int TAG_WIDTH = 5
) (
  input  logic     clk_in,
  input  logic     rst_in,
  reg_file_if.slave bus
);

  logic [31:0]          val_q [REG_NUM];
  logic [31:0]          val_d [REG_NUM];
  logic [TAG_WIDTH-1:0] tag_q [REG_NUM];
  logic [TAG_WIDTH-1:0] tag_d [REG_NUM];

  logic w_commit;
  logic w_commit_match;
  logic w_rename;

  assign w_commit       = bus.commit_en_from_rob && (bus.rd_from_rob != '0);
  assign w_commit_match = (tag_q[bus.rd_from_rob] == bus.Q_from_rob);
  assign w_rename       = bus.rename_en_from_dispatcher && (bus.rename_rd_from_dispatcher != '0);

  // Commit clears the tag only if no younger rename replaced it; rename wins over commit.
  always_comb begin
    val_d = val_q;
    tag_d = tag_q;
    if (bus.rdy_in) begin
      if (w_commit) begin
        val_d[bus.rd_from_rob] = bus.V_from_rob;
        if (w_commit_match) begin
          tag_d[bus.rd_from_rob] = '0;
        end
      end
      if (bus.rollback_in) begin
        for (int i = 0; i < REG_NUM; i++) begin
          tag_d[i] = '0;
        end
      end else if (w_rename) begin
        tag_d[bus.rename_rd_from_dispatcher] = bus.rename_Q_from_dispatcher;
      end
    end
    val_d[0] = '0;
    tag_d[0] = '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      val_q <= val_d;
      tag_q <= tag_d;
    end
  end

  logic [4:0] w_rs [2];
  assign w_rs[0] = bus.rs1_from_dispatcher;
  assign w_rs[1] = bus.rs2_from_dispatcher;

  for (genvar p = 0; p < 2; p++) begin : g_rd_port
    logic [TAG_WIDTH-1:0] w_q;
    logic [31:0]          w_v;

    always_comb begin
      w_q = tag_q[w_rs[p]];
      w_v = val_q[w_rs[p]];
      if (w_rs[p] == '0) begin
        w_q = '0;
        w_v = '0;
      end else if (bus.commit_en_from_rob && (bus.rd_from_rob == w_rs[p]) &&
                   (tag_q[w_rs[p]] == bus.Q_from_rob)) begin
        w_q = '0;
        w_v = bus.V_from_rob;
      end
    end
  end

  assign bus.Q1_to_dispatcher = g_rd_port[0].w_q;
  assign bus.V1_to_dispatcher = g_rd_port[0].w_v;
  assign bus.Q2_to_dispatcher = g_rd_port[1].w_q;
  assign bus.V2_to_dispatcher = g_rd_port[1].w_v;

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// Module : tb_reg_file
// Brief  : Directed and randomized checks of reg_file against a reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_file;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_file_if bus ();

  reg_file dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_v [32];
  logic [4:0]  m_q [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.rdy_in                    = 1'b1;
    bus.rollback_in               = 1'b0;
    bus.commit_en_from_rob        = 1'b0;
    bus.rd_from_rob               = '0;
    bus.Q_from_rob                = '0;
    bus.V_from_rob                = '0;
    bus.rs1_from_dispatcher       = '0;
    bus.rs2_from_dispatcher       = '0;
    bus.rename_en_from_dispatcher = 1'b0;
    bus.rename_rd_from_dispatcher = '0;
    bus.rename_Q_from_dispatcher  = '0;
  endtask

  function automatic logic [36:0] ref_read(input logic [4:0] rs);
    if (rs == 5'd0) return '0;
    if (bus.commit_en_from_rob && bus.rd_from_rob == rs && m_q[rs] == bus.Q_from_rob)
      return {5'd0, bus.V_from_rob};
    return {m_q[rs], m_v[rs]};
  endfunction

  // Let the combinational read ports settle, then compare both against the model.
  task automatic settle();
    logic [36:0] e1, e2;
    #1;
    e1 = ref_read(bus.rs1_from_dispatcher);
    e2 = ref_read(bus.rs2_from_dispatcher);
    chk("Q1", 32'(bus.Q1_to_dispatcher), 32'(e1[36:32]));
    chk("V1", bus.V1_to_dispatcher, e1[31:0]);
    chk("Q2", 32'(bus.Q2_to_dispatcher), 32'(e2[36:32]));
    chk("V2", bus.V2_to_dispatcher, e2[31:0]);
  endtask

  task automatic tick();
    logic [4:0] rd;
    logic       match;
    @(posedge clk);
    rd = bus.rd_from_rob;
    match = (m_q[rd] == bus.Q_from_rob);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_v[i] = '0;
        m_q[i] = '0;
      end
    end else if (bus.rdy_in) begin
      if (bus.commit_en_from_rob && rd != 5'd0) begin
        m_v[rd] = bus.V_from_rob;
        if (match) m_q[rd] = '0;
      end
      if (bus.rollback_in) begin
        for (int i = 0; i < 32; i++) m_q[i] = '0;
      end else if (bus.rename_en_from_dispatcher && bus.rename_rd_from_dispatcher != 5'd0) begin
        m_q[bus.rename_rd_from_dispatcher] = bus.rename_Q_from_dispatcher;
      end
    end
    #1;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [4:0] q);
    idle();
    bus.rename_en_from_dispatcher = 1'b1;
    bus.rename_rd_from_dispatcher = rd;
    bus.rename_Q_from_dispatcher  = q;
    settle();
    tick();
  endtask

  task automatic read2(input logic [4:0] a, input logic [4:0] b);
    idle();
    bus.rs1_from_dispatcher = a;
    bus.rs2_from_dispatcher = b;
    settle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_v[i] = '0;
      m_q[i] = '0;
    end
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // 1: reset state
    read2(5'd5, 5'd0);
    chk("rst_Q1", 32'(bus.Q1_to_dispatcher), 32'd0);
    chk("rst_V1", bus.V1_to_dispatcher, 32'd0);
    chk("rst_Q2", 32'(bus.Q2_to_dispatcher), 32'd0);

    // 2: rename then commit with same-cycle bypass
    rename(5'd3, 5'd4);
    read2(5'd3, 5'd0);
    chk("ren_Q1", 32'(bus.Q1_to_dispatcher), 32'd4);
    bus.commit_en_from_rob = 1'b1;
    bus.rd_from_rob = 5'd3;
    bus.Q_from_rob  = 5'd4;
    bus.V_from_rob  = 32'h55;
    settle();
    chk("byp_Q1", 32'(bus.Q1_to_dispatcher), 32'd0);
    chk("byp_V1", bus.V1_to_dispatcher, 32'h55);
    tick();
    read2(5'd3, 5'd0);
    chk("cmt_Q1", 32'(bus.Q1_to_dispatcher), 32'd0);
    chk("cmt_V1", bus.V1_to_dispatcher, 32'h55);

    // 3: younger rename survives an older commit
    rename(5'd7, 5'd2);
    rename(5'd7, 5'd9);
    idle();
    bus.commit_en_from_rob = 1'b1;
    bus.rd_from_rob = 5'd7;
    bus.Q_from_rob  = 5'd2;
    bus.V_from_rob  = 32'hAA;
    bus.rs1_from_dispatcher = 5'd7;
    settle();
    chk("old_byp_Q1", 32'(bus.Q1_to_dispatcher), 32'd9);
    tick();
    read2(5'd7, 5'd0);
    chk("young_Q", 32'(bus.Q1_to_dispatcher), 32'd9);
    chk("young_V", bus.V1_to_dispatcher, 32'hAA);

    // 4: commit and rename of the same register in one cycle
    rename(5'd8, 5'd3);
    idle();
    bus.commit_en_from_rob = 1'b1;
    bus.rd_from_rob = 5'd8;
    bus.Q_from_rob  = 5'd3;
    bus.V_from_rob  = 32'h11;
    bus.rename_en_from_dispatcher = 1'b1;
    bus.rename_rd_from_dispatcher = 5'd8;
    bus.rename_Q_from_dispatcher  = 5'd6;
    settle();
    tick();
    read2(5'd8, 5'd0);
    chk("both_Q", 32'(bus.Q1_to_dispatcher), 32'd6);
    chk("both_V", bus.V1_to_dispatcher, 32'h11);

    // 5: rollback clears every tag and drops a concurrent rename
    rename(5'd1, 5'd1);
    rename(5'd2, 5'd2);
    rename(5'd4, 5'd4);
    idle();
    bus.rollback_in = 1'b1;
    bus.rename_en_from_dispatcher = 1'b1;
    bus.rename_rd_from_dispatcher = 5'd5;
    bus.rename_Q_from_dispatcher  = 5'd3;
    settle();
    tick();
    read2(5'd1, 5'd5);
    chk("rb_Q1", 32'(bus.Q1_to_dispatcher), 32'd0);
    chk("rb_Q5", 32'(bus.Q2_to_dispatcher), 32'd0);
    read2(5'd2, 5'd4);
    chk("rb_Q2", 32'(bus.Q1_to_dispatcher), 32'd0);
    chk("rb_Q4", 32'(bus.Q2_to_dispatcher), 32'd0);
    read2(5'd3, 5'd7);
    chk("rb_V3", bus.V1_to_dispatcher, 32'h55);
    chk("rb_V7", bus.V2_to_dispatcher, 32'hAA);

    // 6: x0 is immutable, rdy low freezes state
    idle();
    bus.rename_en_from_dispatcher = 1'b1;
    bus.rename_rd_from_dispatcher = 5'd0;
    bus.rename_Q_from_dispatcher  = 5'd5;
    bus.commit_en_from_rob = 1'b1;
    bus.rd_from_rob = 5'd0;
    bus.V_from_rob  = 32'hFF;
    settle();
    tick();
    read2(5'd0, 5'd0);
    chk("x0_Q", 32'(bus.Q1_to_dispatcher), 32'd0);
    chk("x0_V", bus.V1_to_dispatcher, 32'd0);
    rename(5'd9, 5'd7);
    rename(5'd9, 5'd1);
    read2(5'd9, 5'd0);
    chk("ren9_Q", 32'(bus.Q1_to_dispatcher), 32'd1);
    idle();
    bus.rdy_in = 1'b0;
    bus.rename_en_from_dispatcher = 1'b1;
    bus.rename_rd_from_dispatcher = 5'd9;
    bus.rename_Q_from_dispatcher  = 5'd12;
    bus.commit_en_from_rob = 1'b1;
    bus.rd_from_rob = 5'd3;
    bus.V_from_rob  = 32'hDEAD;
    settle();
    tick();
    read2(5'd9, 5'd3);
    chk("hold_Q9", 32'(bus.Q1_to_dispatcher), 32'd1);
    chk("hold_V3", bus.V2_to_dispatcher, 32'h55);

    // Randomized traffic, biased toward low registers so commits, renames and reads collide.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] rd;
      idle();
      rst = ($urandom_range(0, 299) == 0);
      bus.rdy_in      = ($urandom_range(0, 9) != 0);
      bus.rollback_in = ($urandom_range(0, 24) == 0);
      rd = 5'($urandom_range(0, 7));
      bus.commit_en_from_rob = 1'($urandom);
      bus.rd_from_rob = rd;
      bus.Q_from_rob  = ($urandom_range(0, 1) == 1) ? m_q[rd] : 5'($urandom_range(0, 16));
      bus.V_from_rob  = $urandom;
      bus.rename_en_from_dispatcher = 1'($urandom);
      bus.rename_rd_from_dispatcher = 5'($urandom_range(0, 7));
      bus.rename_Q_from_dispatcher  = 5'($urandom_range(1, 16));
      bus.rs1_from_dispatcher = ($urandom_range(0, 3) == 0) ? 5'($urandom) : rd;
      bus.rs2_from_dispatcher = 5'($urandom_range(0, 8));
      settle();
      tick();
    end
    rst = 1'b0;

    for (int i = 0; i < 32; i += 2) begin
      read2(5'(i), 5'(i + 1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
